rom_load_ctrl: RTL and testbench

Sequences the HPS ROM download stream into the Ultra Tank core's on-chip ROMs and owns the core's reset. It decodes the flat download address into per-ROM write strobes and counts accepted bytes. The core is held in reset until a complete, in-range image has landed, then released after a fixed settle period. It sits between hps_io's ioctl port and ultra_tank's dn_* / Reset_n inputs.

---
 rtl/rom_load_pkg.sv | 43 ++++
 rtl/rom_region_decode.sv | 23 ++
 rtl/rom_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_rom_load_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_load_pkg.sv
// Shared types and the ROM image layout for the download sequencer.
// Regions are laid out back to back, so the image size is also the first invalid offset.
package rom_load_pkg;

  typedef enum logic [1:0] {WAIT_DL, LOAD, HOLD, RUN} state_e;

  localparam int unsigned R0_BASE     = 32'h0000;
  localparam int unsigned R0_SIZE     = 2048;
  localparam int unsigned R1_BASE     = 32'h0800;
  localparam int unsigned R1_SIZE     = 2048;
  localparam int unsigned R2_BASE     = 32'h1000;
  localparam int unsigned R2_SIZE     = 1024;
  localparam int unsigned R3_BASE     = 32'h1400;
  localparam int unsigned R3_SIZE     = 1024;
  localparam int unsigned TOTAL_BYTES = R3_BASE + R3_SIZE;

  typedef struct packed {
    logic        valid;
    logic [3:0]  we;
    logic [10:0] rel;
  } region_t;

  function automatic region_t region_of(input logic [31:0] addr);
    region_t r;
    r = '0;
    if (addr < R1_BASE) begin
      r.we  = 4'b0001;
      r.rel = 11'(addr - R0_BASE);
    end else if (addr < R2_BASE) begin
      r.we  = 4'b0010;
      r.rel = 11'(addr - R1_BASE);
    end else if (addr < R3_BASE) begin
      r.we  = 4'b0100;
      r.rel = 11'(addr - R2_BASE);
    end else if (addr < TOTAL_BYTES) begin
      r.we  = 4'b1000;
      r.rel = 11'(addr - R3_BASE);
    end
    r.valid = (addr < TOTAL_BYTES);
    return r;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a flat image offset into a one-hot ROM strobe and
// region-relative address.
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [3:0]        we,
  output logic [10:0]       rel,
  output logic              in_range
);

  region_t r;

  always_comb begin
    r        = region_of(32'(addr));
    we       = r.we;
    rel      = r.rel;
    in_range = r.valid;
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Steers the HPS download stream into the core ROMs and holds the core in reset
// until a complete, in-range image has been written.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk_sys,
  input  logic              Reset_n,
  input  logic              ext_reset,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  output logic [10:0]       rom_addr,
  output logic [7:0]        rom_data,
  output logic [3:0]        rom_we,
  output logic              game_reset_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned   HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic          dl_q, dl_qq;
  logic [12:0]   byte_cnt_q, byte_cnt_d;
  logic          err_q, err_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;
  logic          grn_q, grn_d;
  logic [3:0]    rom_we_q;
  logic [10:0]   rom_addr_q;
  logic [7:0]    rom_data_q;

  logic [3:0]    dec_we;
  logic [10:0]   dec_rel;
  logic          dec_in_range;
  logic          wr_req, accept, rise, start;

  rom_region_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .addr     (dn_addr),
    .we       (dec_we),
    .rel      (dec_rel),
    .in_range (dec_in_range)
  );

  assign wr_req = dn_download & dn_wr;
  assign accept = wr_req & dec_in_range;
  // Edge seen between the two sampled copies, so transitions lag the sampling edge by one cycle.
  assign rise   = dl_q & ~dl_qq;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    start       = 1'b0;
    unique case (state_q)
      WAIT_DL: begin
        if (rise) begin
          state_d = LOAD;
          start   = 1'b1;
        end
      end
      LOAD: begin
        if (!dl_q) begin
          if (byte_cnt_q == 13'(TOTAL_BYTES) && !err_q) begin
            state_d    = HOLD;
            hold_d     = '0;
            load_err_d = 1'b0;
          end else begin
            state_d    = WAIT_DL;
            load_err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (rise) begin
          state_d = LOAD;
          start   = 1'b1;
        end else if (ext_reset) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d     = RUN;
          load_done_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (rise) begin
          state_d = LOAD;
          start   = 1'b1;
        end
      end
      default: state_d = WAIT_DL;
    endcase

    if (start) begin
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
    end

    byte_cnt_d = start ? '0 : byte_cnt_q;
    if (accept && byte_cnt_d != '1) byte_cnt_d = byte_cnt_d + 1'b1;

    err_d = start ? 1'b0 : err_q;
    if (wr_req && !dec_in_range) err_d = 1'b1;

    // Computed from the next state so reset drops on the same edge LOAD is entered.
    grn_d = (state_d == RUN) && !ext_reset;
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= WAIT_DL;
      dl_q        <= 1'b0;
      dl_qq       <= 1'b0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      hold_q      <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      grn_q       <= 1'b0;
      rom_we_q    <= '0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dn_download;
      dl_qq       <= dl_q;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      grn_q       <= grn_d;
      rom_we_q    <= accept ? dec_we : 4'b0000;
      if (accept) begin
        rom_addr_q <= dec_rel;
        rom_data_q <= dn_data;
      end
    end
  end

  assign rom_we       = rom_we_q;
  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign game_reset_n = grn_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: decode table, scoreboarded image loads and reset timing sequences.
module tb_rom_load_ctrl;

  localparam int HOLD  = 16;
  localparam int TOTAL = 6144;

  logic        clk = 1'b0;
  logic        Reset_n, ext_reset, dn_download, dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_we;
  logic        game_reset_n, load_done, load_err;

  always #5 clk = ~clk;

  rom_load_ctrl #(
    .HOLD_CYCLES (HOLD),
    .ADDR_W      (16)
  ) dut (
    .clk_sys      (clk),
    .Reset_n      (Reset_n),
    .ext_reset    (ext_reset),
    .dn_download  (dn_download),
    .dn_wr        (dn_wr),
    .dn_addr      (dn_addr),
    .dn_data      (dn_data),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .rom_we       (rom_we),
    .game_reset_n (game_reset_n),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [3:0]  we;
    logic [10:0] a;
    logic [7:0]  d;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [3:0]  we;
    logic [10:0] raddr;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          mon_en = 1'b0;
  int          reg_cnt[4];
  logic [10:0] last3_a;
  logic [7:0]  last3_d;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Reference: the image is four ROMs laid end to end with sizes 2K, 2K, 1K, 1K.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] d, input int c);
    exp_t e;
    int   ai;
    ai  = int'(a);
    e.c = c;
    e.d = d;
    if (ai < 2048) begin
      e.we = 4'b0001; e.a = 11'(ai);
    end else if (ai < 4096) begin
      e.we = 4'b0010; e.a = 11'(ai - 2048);
    end else if (ai < 5120) begin
      e.we = 4'b0100; e.a = 11'(ai - 4096);
    end else begin
      e.we = 4'b1000; e.a = 11'(ai - 5120);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        mon_e = exp_q.pop_front();
        chk("strobe", {9'd0, rom_we, rom_addr, rom_data}, {9'd0, mon_e.we, mon_e.a, mon_e.d});
      end else if (rom_we != 4'd0) begin
        chk("spurious_strobe", {28'd0, rom_we}, 32'd0);
      end
      for (int r = 0; r < 4; r++) if (rom_we[r]) reg_cnt[r]++;
      if (rom_we[3]) begin
        last3_a = rom_addr;
        last3_d = rom_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dn_wr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    dn_wr   = 1'b1;
    dn_addr = a;
    dn_data = d;
    if (dn_download && int'(a) < TOTAL) exp_q.push_back(model(a, d, cyc + 1));
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  // mode 0: sequential, data = addr[7:0]; 1: sequential, random data; 2: random addresses.
  task automatic load_img(input int n, input int gap_pct, input int mode, input bit extra_oor,
                          input bit chk_drop, output int fall_c, output bit exp_err);
    logic [15:0] a;
    logic [7:0]  d;
    for (int r = 0; r < 4; r++) reg_cnt[r] = 0;
    step();
    dn_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (chk_drop) begin
        chk("reload_grn", {31'd0, game_reset_n}, (i == 2) ? 32'd0 : 32'd1);
        if (i == 2) chk("reload_done", {31'd0, load_done}, 32'd0);
      end
      step();
    end
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) step();
      a = (mode == 2) ? 16'($urandom_range(0, TOTAL - 1)) : 16'(i);
      d = (mode == 0) ? a[7:0] : 8'($urandom);
      wr(a, d);
    end
    if (extra_oor) wr(16'h1800, 8'h5a);
    step();
    dn_download = 1'b0;
    fall_c  = cyc;
    exp_err = (n != TOTAL) || extra_oor;
  endtask

  task automatic check_outcome(input int fall_c, input bit exp_err, input string tag);
    at_cycle(fall_c + 2);
    chk({tag, "_err"}, {31'd0, load_err}, {31'd0, exp_err});
    if (exp_err) begin
      chk({tag, "_grn"}, {31'd0, game_reset_n}, 32'd0);
      chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
    end else begin
      at_cycle(fall_c + 2 + HOLD - 1);
      chk({tag, "_grn_early"}, {31'd0, game_reset_n}, 32'd0);
      chk({tag, "_done_early"}, {31'd0, load_done}, 32'd0);
      at_cycle(fall_c + 2 + HOLD);
      chk({tag, "_grn_rise"}, {31'd0, game_reset_n}, 32'd1);
      chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, {28'd0, rom_we}, 32'd0);
    chk({tag, "_addr"}, {21'd0, rom_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, rom_data}, 32'd0);
    chk({tag, "_grn"}, {31'd0, game_reset_n}, 32'd0);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    vec_t vecs[12];
    int   f, k, p, hi, n;
    bit   e, extra;

    vecs[0]  = '{16'h0000, 8'h11, 4'b0001, 11'h000};
    vecs[1]  = '{16'h07ff, 8'h22, 4'b0001, 11'h7ff};
    vecs[2]  = '{16'h0800, 8'h33, 4'b0010, 11'h000};
    vecs[3]  = '{16'h0fff, 8'h44, 4'b0010, 11'h7ff};
    vecs[4]  = '{16'h1000, 8'h55, 4'b0100, 11'h000};
    vecs[5]  = '{16'h13ff, 8'h66, 4'b0100, 11'h3ff};
    vecs[6]  = '{16'h1400, 8'h77, 4'b1000, 11'h000};
    vecs[7]  = '{16'h17ff, 8'h88, 4'b1000, 11'h3ff};
    vecs[8]  = '{16'h1800, 8'h99, 4'b0000, 11'h000};
    vecs[9]  = '{16'hffff, 8'haa, 4'b0000, 11'h000};
    vecs[10] = '{16'h0a5c, 8'hbb, 4'b0010, 11'h25c};
    vecs[11] = '{16'h1555, 8'hcc, 4'b1000, 11'h155};

    Reset_n = 1'b0; ext_reset = 1'b0; dn_download = 1'b0;
    dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    step();
    Reset_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("idle_grn", {31'd0, game_reset_n}, 32'd0);

    // Decode table, including out-of-range addresses that must never strobe.
    step();
    dn_download = 1'b1;
    repeat (3) step();
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      dn_wr = 1'b1; dn_addr = vecs[i].addr; dn_data = vecs[i].data;
      step();
      @(negedge clk);
      chk("tbl_we", {28'd0, rom_we}, {28'd0, vecs[i].we});
      if (vecs[i].we != 4'd0) begin
        chk("tbl_addr", {21'd0, rom_addr}, {21'd0, vecs[i].raddr});
        chk("tbl_data", {24'd0, rom_data}, {24'd0, vecs[i].data});
      end
    end
    step();
    @(negedge clk);
    chk("tbl_single_pulse", {28'd0, rom_we}, 32'd0);
    step();
    dn_download = 1'b0;
    f = cyc;
    check_outcome(f, 1'b1, "tbl");

    mon_en = 1'b1;

    load_img(TOTAL, 0, 0, 1'b0, 1'b0, f, e);
    check_outcome(f, e, "full");
    chk("full_r0", reg_cnt[0], 2048);
    chk("full_r1", reg_cnt[1], 2048);
    chk("full_r2", reg_cnt[2], 1024);
    chk("full_r3", reg_cnt[3], 1024);
    chk("full_last_r3_addr", {21'd0, last3_a}, 32'h3ff);
    chk("full_last_r3_data", {24'd0, last3_d}, 32'hff);

    // 5-cycle ext_reset pulse in RUN: low for exactly 5 cycles, one cycle late.
    step();
    ext_reset = 1'b1;
    k = cyc;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      chk("ext_run_grn", {31'd0, game_reset_n}, (i >= 1 && i <= 5) ? 32'd0 : 32'd1);
      step();
      if (i == 4) ext_reset = 1'b0;
    end

    // Reload from RUN, then an ext_reset pulse during HOLD pushes the release out.
    load_img(TOTAL, 20, 1, 1'b0, 1'b1, f, e);
    at_cycle(f + 2);
    chk("reload_err", {31'd0, load_err}, 32'd0);
    at_cycle(f + 6);
    step();
    ext_reset = 1'b1;
    p = cyc;
    step();
    step();
    step();
    ext_reset = 1'b0;
    at_cycle(p + 3 + HOLD - 1);
    chk("hold_ext_grn_early", {31'd0, game_reset_n}, 32'd0);
    at_cycle(p + 3 + HOLD);
    chk("hold_ext_grn_rise", {31'd0, game_reset_n}, 32'd1);
    chk("hold_ext_done", {31'd0, load_done}, 32'd1);

    load_img(TOTAL - 1, 20, 1, 1'b0, 1'b0, f, e);
    check_outcome(f, e, "short");
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      @(negedge clk);
      if (game_reset_n) hi++;
    end
    chk("short_held_cycles_high", hi, 0);

    load_img(TOTAL, 10, 0, 1'b1, 1'b0, f, e);
    check_outcome(f, e, "oor");

    for (int it = 0; it < 2; it++) begin
      n     = (it == 0) ? TOTAL : TOTAL + int'($urandom_range(0, 6)) - 3;
      extra = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      load_img(n, 15, 2, extra, 1'b0, f, e);
      check_outcome(f, e, "rand");
    end

    // Abort a load with Reset_n after 3000 bytes, then load cleanly.
    step();
    dn_download = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3000; i++) wr(16'(i), 8'(i));
    step();
    @(negedge clk);
    #1;
    Reset_n     = 1'b0;
    dn_download = 1'b0;
    #1;
    chk_reset_outputs("abort");
    step();
    step();
    Reset_n = 1'b1;
    load_img(TOTAL, 0, 0, 1'b0, 1'b0, f, e);
    check_outcome(f, e, "after_abort");

    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
